// File: rtl/hdlc_tx_framer_if.sv
// Byte-stream and status bundle between a frame source and the HDLC framer.
//   master : frame source; drives Tx_Data/Tx_Valid/Tx_Last/Tx_FCSen/Tx_AbortFrame,
//            observes Tx_Ready, the serial line Tx and the status pulses.
//   slave  : the framer; the mirror image of master.
interface hdlc_tx_framer_if;
  logic [7:0] Tx_Data;
  logic       Tx_Valid;
  logic       Tx_Last;
  logic       Tx_Ready;
  logic       Tx_FCSen;
  logic       Tx_AbortFrame;
  logic       Tx;
  logic       Tx_Busy;
  logic       Tx_Done;
  logic       Tx_Aborted;
  logic       Tx_Underrun;

  modport master (
    output Tx_Data, Tx_Valid, Tx_Last, Tx_FCSen, Tx_AbortFrame,
    input  Tx_Ready, Tx, Tx_Busy, Tx_Done, Tx_Aborted, Tx_Underrun
  );

  modport slave (
    input  Tx_Data, Tx_Valid, Tx_Last, Tx_FCSen, Tx_AbortFrame,
    output Tx_Ready, Tx, Tx_Busy, Tx_Done, Tx_Aborted, Tx_Underrun
  );
endinterface

// File: rtl/hdlc_tx_framer.sv
// Transmit-side HDLC framer. Takes frame bytes over a valid/ready handshake and
// serialises them LSB first at one bit per clock: opening flag 0x7E, payload with
// zero insertion after five consecutive ones, optional inverted CRC-16 FCS, closing
// flag. Aborts (0 followed by seven 1s) are sent on request or on underrun.
// Ports:
//   Clk  : system clock, all state changes on the rising edge
//   Rst  : asynchronous, active-high reset
//   txIf : slave side of hdlc_tx_framer_if (byte handshake, abort request,
//          FCS enable, registered serial output Tx, busy/done/aborted/underrun)
module hdlc_tx_framer #(
  parameter logic [15:0] CRC_POLY   = 16'h8408,
  parameter logic [15:0] CRC_INIT   = 16'hFFFF,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input  logic             Clk,
  input  logic             Rst,
  hdlc_tx_framer_if.slave  txIf
);
  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] START_FLAG = 3'd1;
  localparam logic [2:0] DATA       = 3'd2;
  localparam logic [2:0] FCS        = 3'd3;
  localparam logic [2:0] END_FLAG   = 3'd4;
  localparam logic [2:0] ABORT      = 3'd5;
  localparam logic [7:0] FLAG_BYTE  = 8'h7E;

  // Every register describes the bit currently on Tx: bitCnt is its index within
  // the flag/byte/FCS, stuffReg marks it as an inserted zero, onesCnt counts the
  // run of ones ending with it.
  logic [2:0]  stateReg;
  logic [3:0]  bitCnt;
  logic [15:0] shiftReg;
  logic [2:0]  onesCnt;
  logic        stuffReg;
  logic        lastReg;
  logic        fcsEnReg;
  logic [15:0] crcReg;
  logic        txReg;
  logic        busyReg;
  logic        doneReg;
  logic        abortedReg;

  logic       inFrame;
  logic       abortReq;
  logic       stuffPending;
  logic       byteEnd;
  logic       byteNeeded;
  logic       underrun;
  logic [2:0] flagIdx;

  function automatic logic [15:0] crcStep(input logic [15:0] crc, input logic b);
    crcStep = (crc >> 1) ^ ((crc[0] ^ b) ? CRC_POLY : 16'h0000);
  endfunction

  function automatic logic [2:0] onesStep(input logic [2:0] n, input logic b);
    onesStep = b ? n + 3'd1 : 3'd0;
  endfunction

  assign inFrame      = (stateReg != IDLE) && (stateReg != ABORT);
  assign abortReq     = txIf.Tx_AbortFrame && inFrame;
  assign stuffPending = ((stateReg == DATA) || (stateReg == FCS)) && !stuffReg && (onesCnt == 3'd5);
  assign byteEnd      = (bitCnt[2:0] == 3'd7);
  // When the last bit of a byte completes a run of five ones, the trailing stuffed
  // zero is the byte's final wire cycle, so the handoff moves into that cycle.
  assign byteNeeded   = ((stateReg == START_FLAG) && byteEnd) ||
                        ((stateReg == DATA) && byteEnd && !stuffPending && !lastReg);
  assign underrun     = byteNeeded && !txIf.Tx_Valid;
  assign flagIdx      = bitCnt[2:0] + 3'd1;

  assign txIf.Tx_Ready    = byteNeeded && !abortReq;
  assign txIf.Tx_Underrun = underrun;
  assign txIf.Tx          = txReg;
  assign txIf.Tx_Busy     = busyReg;
  assign txIf.Tx_Done     = doneReg;
  assign txIf.Tx_Aborted  = abortedReg;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stateReg   <= IDLE;
      bitCnt     <= 4'd0;
      shiftReg   <= 16'h0000;
      onesCnt    <= 3'd0;
      stuffReg   <= 1'b0;
      lastReg    <= 1'b0;
      fcsEnReg   <= 1'b0;
      crcReg     <= CRC_INIT;
      txReg      <= IDLE_LEVEL;
      busyReg    <= 1'b0;
      doneReg    <= 1'b0;
      abortedReg <= 1'b0;
    end else begin
      doneReg    <= 1'b0;
      abortedReg <= 1'b0;
      if (abortReq || underrun) begin
        // Current bit is abandoned; the abort pattern starts with its leading 0.
        stateReg <= ABORT;
        bitCnt   <= 4'd0;
        txReg    <= 1'b0;
        stuffReg <= 1'b0;
        onesCnt  <= 3'd0;
      end else begin
        case (stateReg)
          IDLE: begin
            if (txIf.Tx_Valid) begin
              stateReg <= START_FLAG;
              bitCnt   <= 4'd0;
              txReg    <= FLAG_BYTE[0];
              fcsEnReg <= txIf.Tx_FCSen;
              crcReg   <= CRC_INIT;
              onesCnt  <= 3'd0;
              stuffReg <= 1'b0;
              busyReg  <= 1'b1;
            end
          end
          START_FLAG, DATA: begin
            if (stuffPending) begin
              txReg    <= 1'b0;
              stuffReg <= 1'b1;
              onesCnt  <= 3'd0;
            end else if (byteEnd && (stateReg == START_FLAG || !lastReg)) begin
              // Handoff cycle; underrun was ruled out above, so the byte is valid.
              stateReg <= DATA;
              bitCnt   <= 4'd0;
              shiftReg <= {8'h00, txIf.Tx_Data};
              lastReg  <= txIf.Tx_Last;
              txReg    <= txIf.Tx_Data[0];
              stuffReg <= 1'b0;
              crcReg   <= crcStep(crcReg, txIf.Tx_Data[0]);
              onesCnt  <= onesStep(onesCnt, txIf.Tx_Data[0]);
            end else if (byteEnd && fcsEnReg) begin
              stateReg <= FCS;
              bitCnt   <= 4'd0;
              shiftReg <= ~crcReg;
              txReg    <= ~crcReg[0];
              stuffReg <= 1'b0;
              onesCnt  <= onesStep(onesCnt, ~crcReg[0]);
            end else if (byteEnd) begin
              stateReg <= END_FLAG;
              bitCnt   <= 4'd0;
              txReg    <= FLAG_BYTE[0];
              stuffReg <= 1'b0;
              onesCnt  <= 3'd0;
            end else if (stateReg == START_FLAG) begin
              bitCnt <= bitCnt + 4'd1;
              txReg  <= FLAG_BYTE[flagIdx];
            end else begin
              bitCnt   <= bitCnt + 4'd1;
              shiftReg <= shiftReg >> 1;
              txReg    <= shiftReg[1];
              stuffReg <= 1'b0;
              crcReg   <= crcStep(crcReg, shiftReg[1]);
              onesCnt  <= onesStep(onesCnt, shiftReg[1]);
            end
          end
          FCS: begin
            if (stuffPending) begin
              txReg    <= 1'b0;
              stuffReg <= 1'b1;
              onesCnt  <= 3'd0;
            end else if (bitCnt == 4'd15) begin
              stateReg <= END_FLAG;
              bitCnt   <= 4'd0;
              txReg    <= FLAG_BYTE[0];
              stuffReg <= 1'b0;
              onesCnt  <= 3'd0;
            end else begin
              // CRC is frozen while its complement is on the wire.
              bitCnt   <= bitCnt + 4'd1;
              shiftReg <= shiftReg >> 1;
              txReg    <= shiftReg[1];
              stuffReg <= 1'b0;
              onesCnt  <= onesStep(onesCnt, shiftReg[1]);
            end
          end
          END_FLAG: begin
            if (byteEnd) begin
              stateReg <= IDLE;
              txReg    <= IDLE_LEVEL;
              busyReg  <= 1'b0;
              doneReg  <= 1'b1;
            end else begin
              bitCnt <= bitCnt + 4'd1;
              txReg  <= FLAG_BYTE[flagIdx];
            end
          end
          ABORT: begin
            if (byteEnd) begin
              stateReg   <= IDLE;
              txReg      <= IDLE_LEVEL;
              busyReg    <= 1'b0;
              abortedReg <= 1'b1;
            end else begin
              bitCnt <= bitCnt + 4'd1;
              txReg  <= 1'b1;
            end
          end
          default: stateReg <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Self-checking bench for hdlc_tx_framer. A reference model builds the expected
// wire bit stream of each frame from its bytes (flags, zero insertion, CRC-16
// FCS), plus the cycles where a byte is requested; directed and random frames,
// aborts, underruns and a mid-frame reset are compared against it.
module tb_hdlc_tx_framer;
  logic Clk = 1'b0;
  logic Rst;

  hdlc_tx_framer_if txIf();

  hdlc_tx_framer dut (
    .Clk  (Clk),
    .Rst  (Rst),
    .txIf (txIf)
  );

  always #5 Clk = ~Clk;

  int checkCount = 0;
  int failCount  = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] frameBytes [16];
  logic [7:0] flagPattern = 8'h7E;
  bit         expBits[$];
  int         handoffPos[$];
  int         onesRun;

  task automatic pushStuffed(input bit b);
    expBits.push_back(b);
    if (b) onesRun++; else onesRun = 0;
    if (onesRun == 5) begin
      expBits.push_back(1'b0);
      onesRun = 0;
    end
  endtask

  task automatic buildModel(input int n, input bit fcsEn);
    logic [15:0] crc;
    logic [15:0] fcs;
    bit b;
    expBits.delete();
    handoffPos.delete();
    onesRun = 0;
    crc = 16'hFFFF;
    for (int i = 0; i < 8; i++) expBits.push_back(flagPattern[i]);
    handoffPos.push_back(8);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 8; i++) begin
        b = frameBytes[k][i];
        crc = (crc >> 1) ^ ((crc[0] ^ b) ? 16'h8408 : 16'h0000);
        pushStuffed(b);
      end
      if (k != n - 1) handoffPos.push_back(expBits.size());
    end
    if (fcsEn) begin
      fcs = ~crc;
      for (int i = 0; i < 16; i++) pushStuffed(fcs[i]);
    end
    for (int i = 0; i < 8; i++) expBits.push_back(flagPattern[i]);
  endtask

  // ---------------- stimulus / capture ----------------
  logic gotBits[$];
  int   readyPos[$];
  int   underrunPos[$];
  int   takenCount;
  logic sawDone, sawAborted, endTx;
  bit   resetHit;
  int   frameNo = 0;

  task automatic runFrame(input int n, input bit fcsEn, input int abortAt, input int dropAt, input int resetAt);
    int idx;
    int cycles;
    bit finished;
    gotBits.delete();
    readyPos.delete();
    underrunPos.delete();
    takenCount = 0;
    sawDone = 1'b0;
    sawAborted = 1'b0;
    endTx = 1'b0;
    resetHit = 1'b0;
    idx = 0;
    cycles = 0;
    finished = 1'b0;
    while (!finished && cycles < 3000) begin
      @(negedge Clk);
      txIf.Tx_Valid      = (idx < n) && !(dropAt >= 0 && idx >= dropAt);
      txIf.Tx_Data       = (idx < n) ? frameBytes[idx] : 8'h00;
      txIf.Tx_Last       = (idx == n - 1);
      txIf.Tx_FCSen      = fcsEn;
      txIf.Tx_AbortFrame = (txIf.Tx_Busy === 1'b1) && (gotBits.size() + 1 == abortAt);
      #1;
      if (txIf.Tx_Busy === 1'b1) begin
        gotBits.push_back(txIf.Tx);
        if (txIf.Tx_Ready === 1'b1) readyPos.push_back(gotBits.size());
        if (txIf.Tx_Underrun === 1'b1) underrunPos.push_back(gotBits.size());
        if (txIf.Tx_Ready === 1'b1 && txIf.Tx_Valid) begin
          takenCount++;
          idx++;
        end
        if (resetAt > 0 && gotBits.size() == resetAt) begin
          Rst = 1'b1;
          #1;
          checkVal("rst.tx", txIf.Tx, 1);
          checkVal("rst.busy", txIf.Tx_Busy, 0);
          checkVal("rst.done", txIf.Tx_Done, 0);
          checkVal("rst.aborted", txIf.Tx_Aborted, 0);
          checkVal("rst.ready", txIf.Tx_Ready, 0);
          checkVal("rst.underrun", txIf.Tx_Underrun, 0);
          resetHit = 1'b1;
          finished = 1'b1;
        end
      end else if (txIf.Tx_Done === 1'b1 || txIf.Tx_Aborted === 1'b1) begin
        sawDone    = txIf.Tx_Done;
        sawAborted = txIf.Tx_Aborted;
        endTx      = txIf.Tx;
        finished   = 1'b1;
      end
      cycles++;
    end
    txIf.Tx_Valid      = 1'b0;
    txIf.Tx_AbortFrame = 1'b0;
    checkVal("frame.finished", finished, 1);
  endtask

  task automatic checkFrame(input string tag, input int n, input bit fcsEn, input int abortAt, input int dropAt);
    bit expStream[$];
    int expReady[$];
    int stopPos, underAt, expTaken;
    bit aborting, expUnder;
    buildModel(n, fcsEn);
    stopPos = expBits.size();
    aborting = 1'b0;
    underAt = -1;
    if (dropAt >= 0) underAt = handoffPos[dropAt];
    if (abortAt > 0 && (underAt < 0 || abortAt <= underAt)) begin
      stopPos = abortAt;
      aborting = 1'b1;
    end else if (underAt >= 0) begin
      stopPos = underAt;
      aborting = 1'b1;
    end
    expUnder = (underAt >= 0) && (underAt <= stopPos);
    for (int i = 0; i < stopPos; i++) expStream.push_back(expBits[i]);
    if (aborting) begin
      expStream.push_back(1'b0);
      for (int i = 0; i < 7; i++) expStream.push_back(1'b1);
    end
    expTaken = 0;
    foreach (handoffPos[k]) begin
      if (handoffPos[k] < stopPos) begin
        expReady.push_back(handoffPos[k]);
        expTaken++;
      end else if (handoffPos[k] == stopPos && abortAt != stopPos) begin
        expReady.push_back(handoffPos[k]);
      end
    end

    runFrame(n, fcsEn, abortAt, dropAt, 0);

    checkVal($sformatf("%s.len", tag), gotBits.size(), expStream.size());
    for (int i = 0; i < expStream.size() && i < gotBits.size(); i++) begin
      checkVal($sformatf("%s.bit%0d", tag, i), gotBits[i], expStream[i]);
      if (gotBits[i] !== expStream[i]) break;
    end
    checkVal($sformatf("%s.readyCount", tag), readyPos.size(), expReady.size());
    for (int i = 0; i < expReady.size() && i < readyPos.size(); i++)
      checkVal($sformatf("%s.readyPos%0d", tag, i), readyPos[i], expReady[i]);
    checkVal($sformatf("%s.taken", tag), takenCount, expTaken);
    checkVal($sformatf("%s.underrun", tag), underrunPos.size(), expUnder);
    if (expUnder && underrunPos.size() > 0)
      checkVal($sformatf("%s.underrunPos", tag), underrunPos[0], underAt);
    checkVal($sformatf("%s.done", tag), sawDone, !aborting);
    checkVal($sformatf("%s.aborted", tag), sawAborted, aborting);
    checkVal($sformatf("%s.idleLevel", tag), endTx, 1);
    $display("frame %0d %s: bytes=%0d fcs=%0d abortAt=%0d dropAt=%0d wireBits=%0d taken=%0d",
             frameNo, tag, n, fcsEn, abortAt, dropAt, gotBits.size(), takenCount);
    frameNo++;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic plain[$];
    int run;
    bit skip;
    logic [15:0] fcsWire;
    int rAt, n, mode, abortAt, dropAt;
    bit fcsEn;

    Rst = 1'b1;
    txIf.Tx_Data = 8'h00;
    txIf.Tx_Valid = 1'b0;
    txIf.Tx_Last = 1'b0;
    txIf.Tx_FCSen = 1'b0;
    txIf.Tx_AbortFrame = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    checkVal("reset.tx", txIf.Tx, 1);
    checkVal("reset.busy", txIf.Tx_Busy, 0);
    checkVal("reset.done", txIf.Tx_Done, 0);
    checkVal("reset.aborted", txIf.Tx_Aborted, 0);
    checkVal("reset.ready", txIf.Tx_Ready, 0);
    checkVal("reset.underrun", txIf.Tx_Underrun, 0);
    @(negedge Clk);
    Rst = 1'b0;
    repeat (2) @(negedge Clk);

    frameBytes[0] = 8'h00;
    checkFrame("oneByte", 1, 1'b0, 0, -1);

    for (int k = 0; k < 9; k++) frameBytes[k] = 8'h31 + 8'(k);
    checkFrame("check9", 9, 1'b1, 0, -1);
    run = 0;
    skip = 1'b0;
    for (int i = 8; i < gotBits.size() - 8; i++) begin
      if (skip) begin
        skip = 1'b0;
        run = 0;
      end else begin
        plain.push_back(gotBits[i]);
        if (gotBits[i] === 1'b1) run++; else run = 0;
        if (run == 5) skip = 1'b1;
      end
    end
    checkVal("check9.plainLen", plain.size(), 9 * 8 + 16);
    if (plain.size() >= 16) begin
      for (int i = 0; i < 16; i++) fcsWire[i] = plain[plain.size() - 16 + i];
      checkVal("check9.fcsWire", fcsWire, 16'h906E);
    end

    frameBytes[0] = 8'hFF;
    frameBytes[1] = 8'h1F;
    checkFrame("ff1f", 2, 1'b0, 0, -1);
    checkVal("ff1f.dataLen", gotBits.size() - 16, 18);

    frameBytes[0] = 8'h00;
    frameBytes[1] = 8'h11;
    frameBytes[2] = 8'h22;
    checkFrame("abort4th", 3, 1'b0, 12, -1);
    checkFrame("underrun", 3, 1'b0, 0, 1);

    for (int k = 0; k < 9; k++) frameBytes[k] = 8'h31 + 8'(k);
    buildModel(9, 1'b1);
    rAt = expBits.size() - 8 - 6;
    runFrame(9, 1'b1, 0, -1, rAt);
    checkVal("rst.hit", resetHit, 1);
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    frameBytes[0] = 8'hA5;
    checkFrame("afterRst", 1, 1'b1, 0, -1);

    for (int f = 0; f < 24; f++) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 3))
          0:       frameBytes[k] = 8'hFF;
          1:       frameBytes[k] = 8'hF8;
          default: frameBytes[k] = 8'($urandom);
        endcase
      end
      fcsEn = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 2);
      abortAt = 0;
      dropAt = -1;
      buildModel(n, fcsEn);
      if (mode == 1) begin
        abortAt = $urandom_range(1, expBits.size());
      end else if (mode == 2 && n >= 2) begin
        dropAt = $urandom_range(1, n - 1);
        if ($urandom_range(0, 1) == 1) abortAt = handoffPos[dropAt];
      end
      checkFrame($sformatf("rand%0d", f), n, fcsEn, abortAt, dropAt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end
endmodule
